// File: rtl/btn_debounce_pkg.sv
// Shared constants and types for the 250 Hz push-button debouncer.
// Optional auto-repeat is enabled by defining BTN_DEBOUNCE_REPEAT_EN.
package btn_debounce_pkg;

  localparam int STABLE_TICKS_DEF = 5;
  localparam int HOLD_TICKS_DEF   = 125;
  localparam int REPEAT_TICKS_DEF = 25;
  localparam int CNT_W_DEF        = 8;

  // Per-channel event decided on a tick, registered into the pulse outputs.
  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_PRESS   = 2'd1,
    EV_RELEASE = 2'd2,
    EV_REPEAT  = 2'd3
  } btn_event_e;

  // True when a CNT_W-bit counter can hold every tick count the channel needs.
  function automatic bit cnt_fits(input int w, input int stable, input int hold,
                                  input int rpt);
    int max_v;
    max_v = stable;
    if (hold > max_v) max_v = hold;
    if (rpt > max_v) max_v = rpt;
    return (w < 31) && (max_v < (1 << w)) && (stable >= 1) && (rpt >= 1)
           && (rpt <= hold);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, level and pulse
// registers. Auto-repeat hold counter exists only with BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  generate
    if (!cnt_fits(CNT_W, STABLE_TICKS, HOLD_TICKS, REPEAT_TICKS)) begin : g_bad_cfg
      $error("btn_debounce_ch: CNT_W too narrow or tick parameters illegal");
    end
  endgenerate

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, release_q;
  btn_event_e       event_d;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_BASE = CNT_W'(HOLD_TICKS - REPEAT_TICKS);
  logic [CNT_W-1:0] hold_q, hold_d;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    event_d = EV_NONE;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        level_d = ~level_q;
        event_d = level_q ? EV_RELEASE : EV_PRESS;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    // Hold count restarts at acceptance; after the first repeat it is rewound
    // so the next repeat lands REPEAT_TICKS later.
    hold_d = hold_q;
    if (!level_q) begin
      hold_d = '0;
    end else if (tick_i) begin
      if (hold_q == HOLD_LAST) begin
        hold_d = REPEAT_BASE;
        if (event_d == EV_NONE) event_d = EV_REPEAT;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= (event_d == EV_PRESS) || (event_d == EV_REPEAT);
      release_q <= (event_d == EV_RELEASE);
    end
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce_250hz.sv
// N-channel push-button debouncer sampled on rising edges of CLK_250hz, which is
// edge-detected as data in the CLK domain. Auto-repeat via BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce_250hz
  import btn_debounce_pkg::*;
#(
  parameter int N            = 4,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CLK_250hz,
  input  logic [N-1:0] BTN_IN,
  output logic [N-1:0] BTN_LEVEL,
  output logic [N-1:0] BTN_PRESS,
  output logic [N-1:0] BTN_RELEASE
);

  logic clk_q;
  logic tick;

  // Delay flop resets low, so a divider already high at reset release ticks once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_q <= 1'b0;
    end else begin
      clk_q <= CLK_250hz;
    end
  end

  assign tick = CLK_250hz & ~clk_q;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      btn_debounce_ch #(
        .STABLE_TICKS(STABLE_TICKS),
        .CNT_W       (CNT_W),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
      ) u_ch (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .tick_i   (tick),
        .btn_i    (BTN_IN[gi]),
        .level_o  (BTN_LEVEL[gi]),
        .press_o  (BTN_PRESS[gi]),
        .release_o(BTN_RELEASE[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce_250hz.sv
// Directed bench for btn_debounce_250hz; CLK_250hz is emulated as a 20-cycle
// square wave so each call of do_ticks produces exactly one sample strobe per tick.
module tb_btn_debounce_250hz;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CLK_250hz;
  logic [3:0] BTN_IN;
  logic [3:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tick_no = 0;
  int rise_cyc = 0;
  int press_cnt[4], rel_cnt[4], press_tick[4], press_cyc[4], rel_cyc[4];
  int width_err = 0;
  int excl_err = 0;
  logic [3:0] prev_press = '0, prev_rel = '0;
  int base, sum_before, sum_after;

  btn_debounce_250hz dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CLK_250hz  (CLK_250hz),
    .BTN_IN     (BTN_IN),
    .BTN_LEVEL  (BTN_LEVEL),
    .BTN_PRESS  (BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; press_tick[i] = -1;
      press_cyc[i] = -1; rel_cyc[i] = -1;
    end
  end

  // Pulse monitor: counts pulses, stamps them, flags wide or overlapping pulses.
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (BTN_PRESS[i]) begin
        press_cnt[i]++; press_tick[i] = tick_no; press_cyc[i] = cyc;
        if (prev_press[i]) width_err++;
      end
      if (BTN_RELEASE[i]) begin
        rel_cnt[i]++; rel_cyc[i] = cyc;
        if (prev_rel[i]) width_err++;
      end
      if (BTN_PRESS[i] && BTN_RELEASE[i]) excl_err++;
    end
    prev_press = BTN_PRESS;
    prev_rel   = BTN_RELEASE;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Low phase first so input changes made before the call are synchronized
  // before the strobe; the strobe edge is the posedge after CLK_250hz rises.
  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (10) @(negedge CLK);
      CLK_250hz = 1'b1;
      tick_no++;
      rise_cyc = cyc;
      repeat (10) @(negedge CLK);
      CLK_250hz = 1'b0;
    end
  endtask

  initial begin
    RESET = 1'b0; CLK_250hz = 1'b0; BTN_IN = 4'hF;

    // Reset hold with all buttons high
    repeat (5) @(negedge CLK);
    chk("rst_level", 32'(BTN_LEVEL), 32'h0);
    chk("rst_press", 32'(BTN_PRESS), 32'h0);
    chk("rst_release", 32'(BTN_RELEASE), 32'h0);
    BTN_IN = 4'h0;
    @(negedge CLK); RESET = 1'b1;
    do_ticks(3);
    chk("idle_level", 32'(BTN_LEVEL), 32'h0);
    chk("idle_press_sum", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 0);

    // Clean press on ch0: accepted on 5th tick, pulse one CLK after strobe edge
    BTN_IN = 4'b0001;
    do_ticks(4);
    chk("ch0_level_4ticks", 32'(BTN_LEVEL), 32'h0);
    do_ticks(1);
    chk("ch0_level_5ticks", 32'(BTN_LEVEL), 32'h1);
    chk("ch0_press_cnt", 32'(press_cnt[0]), 1);
    chk("ch0_press_tick", 32'(press_tick[0]), 32'(tick_no));
    chk("ch0_press_delay", 32'(press_cyc[0] - rise_cyc), 1);
    do_ticks(1);
    chk("ch0_press_once", 32'(press_cnt[0]), 1);

    // Bounce on ch1: 4 high, 1 low, 3 high -> rejected; 5 consecutive -> accepted
    BTN_IN[1] = 1'b1; do_ticks(4);
    BTN_IN[1] = 1'b0; do_ticks(1);
    BTN_IN[1] = 1'b1; do_ticks(3);
    chk("ch1_bounce_press", 32'(press_cnt[1]), 0);
    do_ticks(1);
    chk("ch1_level_4consec", 32'(BTN_LEVEL), 32'h1);
    do_ticks(1);
    chk("ch1_level_5consec", 32'(BTN_LEVEL), 32'h3);
    chk("ch1_press_cnt", 32'(press_cnt[1]), 1);

    // ch2/ch3 press then simultaneous release
    BTN_IN = 4'b1111; do_ticks(5);
    chk("ch23_level_press", 32'(BTN_LEVEL), 32'hF);
    BTN_IN = 4'b0011; do_ticks(4);
    chk("ch23_level_4ticks", 32'(BTN_LEVEL), 32'hF);
    do_ticks(1);
    chk("ch23_level_rel", 32'(BTN_LEVEL), 32'h3);
    chk("ch2_rel_cnt", 32'(rel_cnt[2]), 1);
    chk("ch3_rel_cnt", 32'(rel_cnt[3]), 1);
    chk("ch23_rel_same_cyc", 32'(rel_cyc[3] - rel_cyc[2]), 0);
    chk("ch01_no_release", 32'(rel_cnt[0] + rel_cnt[1]), 0);

    // No-tick freeze with inputs toggling
    sum_before = 0;
    for (int i = 0; i < 4; i++) sum_before += press_cnt[i] + rel_cnt[i];
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK); BTN_IN = 4'($urandom_range(0, 15));
    end
    BTN_IN = 4'b0011;
    repeat (5) @(negedge CLK);
    sum_after = 0;
    for (int i = 0; i < 4; i++) sum_after += press_cnt[i] + rel_cnt[i];
    chk("freeze_level", 32'(BTN_LEVEL), 32'h3);
    chk("freeze_pulses", 32'(sum_after - sum_before), 0);

    // Mid-count reset on ch2: progress discarded, full 5 ticks needed again
    BTN_IN = 4'b0111; do_ticks(3);
    @(negedge CLK); RESET = 1'b0;
    #1;
    chk("async_rst_level", 32'(BTN_LEVEL), 32'h0);
    @(negedge CLK); RESET = 1'b1;
    base = press_cnt[2];
    do_ticks(4);
    chk("post_rst_level_4", 32'(BTN_LEVEL), 32'h0);
    do_ticks(1);
    chk("post_rst_level_5", 32'(BTN_LEVEL), 32'h7);
    chk("post_rst_ch2_press", 32'(press_cnt[2] - base), 1);

    // Long hold on ch0: auto-repeat count depends on build
    BTN_IN = 4'b0000; do_ticks(5);
    chk("all_released", 32'(BTN_LEVEL), 32'h0);
    base = press_cnt[0];
    BTN_IN = 4'b0001; do_ticks(200);
    chk("hold_level", 32'(BTN_LEVEL), 32'h1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
    chk("hold_press_cnt", 32'(press_cnt[0] - base), 4);
`else
    chk("hold_press_cnt", 32'(press_cnt[0] - base), 1);
`endif

    chk("pulse_width_err", 32'(width_err), 0);
    chk("press_rel_overlap", 32'(excl_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_debounce_250hz.md
Name: btn_debounce_250hz

Overview:
- Downstream consumer of the 250 Hz divided clock: uses each rising edge of CLK_250hz as a sample strobe to debounce N asynchronous push-button inputs.
- Produces clean levels plus single-CLK-cycle press/release pulses for the control logic.
- CLK_250hz is treated as a data signal in the CLK domain (edge-detected), never as a clock, so the block has one clock domain.

Parameters:
- N, 4, number of button channels.
- STABLE_TICKS, 5, consecutive differing samples required to accept a change (5 x 4 ms = 20 ms).
- CNT_W, 8, width of the per-channel tick counters; must hold max(STABLE_TICKS, HOLD_TICKS, REPEAT_TICKS).
- HOLD_TICKS, 125, ticks held before the first auto-repeat (500 ms); used only with the optional feature.
- REPEAT_TICKS, 25, ticks between auto-repeats (100 ms); used only with the optional feature.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset.
- CLK_250hz  input  1  divided clock from CLK_250hz_cond, synchronous to CLK.
- BTN_IN  input  N  raw button inputs, asynchronous, active-high.
- BTN_LEVEL  output  N  debounced level.
- BTN_PRESS  output  N  one-CLK pulse on an accepted 0->1 transition (and on auto-repeat when enabled).
- BTN_RELEASE  output  N  one-CLK pulse on an accepted 1->0 transition.

Behaviour:
- Reset (RESET=0, asynchronous): all outputs are 0. Synchronizer flops, the CLK_250hz delay flop and all counters are 0.
- Tick generation: clk_q <= CLK_250hz; tick = CLK_250hz & ~clk_q, lasting 1 CLK cycle.
  - clk_q resets to 0, so if CLK_250hz is high on the first cycle after reset release, a tick fires.
- Input synchronization: each BTN_IN bit passes through a 2-flop synchronizer (sample s).
- Per-channel debounce, evaluated only on tick:
  - If s == BTN_LEVEL, the counter clears to 0.
  - If s != BTN_LEVEL and counter == STABLE_TICKS-1, BTN_LEVEL flips, the counter clears, and BTN_PRESS (if new level is 1) or BTN_RELEASE (if 0) is asserted for exactly one CLK cycle.
  - Otherwise, if s != BTN_LEVEL, the counter increments.
  - Between ticks, the counter and level hold.
- Glitch rule: any single tick where s equals the current level restarts the count. A bounce shorter than STABLE_TICKS consecutive ticks is never accepted.
- Latency: an input change stable from tick k is accepted on tick k+STABLE_TICKS-1. Add 2 CLK for synchronization plus 1 CLK for the registered outputs.
- PRESS and RELEASE are registered and mutually exclusive per channel. Pulses are deasserted on the cycle after assertion.
- Channels are fully independent; simultaneous accepted transitions on several channels pulse in the same cycle.
- Counter saturation: the counter never exceeds STABLE_TICKS-1 in debounce mode. No wrap-around is possible with legal parameters.
- CLK_250hz stuck high or low: no ticks occur, and all state holds indefinitely.
- Reset mid-count: all progress is discarded and outputs return to 0 asynchronously.

Optional Feature:
- Macro: BTN_DEBOUNCE_REPEAT_EN.
- Defined: while BTN_LEVEL=1, a separate hold counter counts ticks from acceptance.
  - On tick HOLD_TICKS, one extra BTN_PRESS pulse is emitted.
  - After that, one extra pulse is emitted every REPEAT_TICKS ticks.
  - The hold counter clears on release or reset.
- Not defined: hold-counter logic is absent, HOLD_TICKS and REPEAT_TICKS are ignored, and BTN_PRESS fires exactly once per accepted press.

Decomposition:
- Shared package/include btn_debounce_pkg:
  - default constants STABLE_TICKS_DEF=5, HOLD_TICKS_DEF=125, REPEAT_TICKS_DEF=25;
  - CNT_W_DEF=8.
- Top level: tick edge detector and generate loop over N.
- Sub-module btn_debounce_ch: one channel containing synchronizer, counter, level register, pulse registers and optional repeat counter.

Test Plan:
- Reset hold: RESET=0 for 5 cycles with BTN_IN=4'hF -> BTN_LEVEL=0, PRESS=0, RELEASE=0; no change until RESET=1 and ticks arrive.
- Clean press on ch0: BTN_IN[0] 0->1 held -> BTN_LEVEL[0]=1 on the 5th tick after the change (+3 CLK) -> BTN_PRESS[0]=1 for exactly 1 CLK; other channels stay 0.
- Bounce rejection on ch1: toggle BTN_IN[1] high 4 ticks, low 1 tick, high 3 ticks -> no PRESS. Continue holding high -> PRESS only after 5 consecutive high ticks.
- Release and simultaneity: ch2 and ch3 held high then released at the same time -> both RELEASE pulses in the same CLK cycle, both levels return to 0.
- No-tick freeze: CLK_250hz held at 0 for 10 ms with BTN_IN toggling -> outputs unchanged. Mid-count RESET pulse -> counters lost, full 5 ticks required again.
- With BTN_DEBOUNCE_REPEAT_EN, hold ch0 for 200 ticks -> PRESS at acceptance, then at +125, +150 and +175 ticks (4 pulses). Without the macro -> exactly 1 pulse.
